// File: rtl/pdm_transmisor.sv
// rtl/pdm_transmisor.sv - first-order sigma-delta PCM to PDM transmitter with 1-entry sample buffer
module pdm_transmisor #(
   parameter int W   = 8,
   parameter int DIV = 4,
   parameter int OSR = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic         pdm_clk,
   output logic         pdm_out,
   output logic         busy,
   output logic         underrun
);

   localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int BW = (OSR > 2) ? $clog2(OSR) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q;
   logic [W-1:0]  buf_q;
   logic          full_q;
   logic [W-1:0]  cur_q;
   logic [W-1:0]  acc_q;
   logic [DW-1:0] div_q;
   logic [BW-1:0] bit_q;
   logic          pdm_clk_q;
   logic          pdm_out_q;
   logic          busy_q;
   logic          underrun_q;
   logic          s_ready_q;

   logic          bit_tick;
   logic          boundary;
   logic          accept;
   logic          drain;
   logic          full_d;
   logic [DW-1:0] div_d;
   logic [BW-1:0] bit_d;
   logic [W:0]    sum;

   // Tick/boundary decode, buffer occupancy and the W+1 bit modulator sum
   always_comb begin
      bit_tick = (state_q == RUN) && (div_q == DW'(DIV - 1));
      boundary = bit_tick && (bit_q == BW'(OSR - 1));
      accept   = s_valid && s_ready_q;
      // The buffer drains either on RUN entry or at a sample boundary that stays in RUN;
      // it can never also be accepting because that needs it empty.
      drain    = full_q && en && ((state_q == IDLE) || boundary);
      if (accept) begin
         full_d = 1'b1;
      end else if (drain) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
      div_d = bit_tick ? '0 : div_q + DW'(1);
      bit_d = boundary ? '0 : bit_q + BW'(1);
      sum   = {1'b0, acc_q} + {1'b0, cur_q};
   end

   // Sample buffer, IDLE/RUN sequencer, divider, bit counter and modulator state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         full_q     <= 1'b0;
         cur_q      <= '0;
         acc_q      <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         pdm_clk_q  <= 1'b0;
         pdm_out_q  <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         s_ready_q  <= 1'b1;
      end else begin
         underrun_q <= 1'b0;
         if (accept) begin
            buf_q <= s_data;
         end
         full_q    <= full_d;
         s_ready_q <= ~full_d;

         case (state_q)
            IDLE: begin
               div_q     <= '0;
               bit_q     <= '0;
               acc_q     <= '0;
               pdm_out_q <= 1'b0;
               pdm_clk_q <= 1'b0;
               busy_q    <= 1'b0;
               if (en && full_q) begin
                  state_q   <= RUN;
                  cur_q     <= buf_q;
                  busy_q    <= 1'b1;
                  // Divider restarts at 0, which is the high half of pdm_clk.
                  pdm_clk_q <= 1'b1;
               end
            end
            RUN: begin
               div_q     <= div_d;
               pdm_clk_q <= (div_d < DW'(DIV / 2));
               if (bit_tick) begin
                  // New bit and the pdm_clk rising edge land on the same clk edge.
                  acc_q     <= sum[W-1:0];
                  pdm_out_q <= sum[W];
                  bit_q     <= bit_d;
                  if (boundary) begin
                     if (!en) begin
                        // Stop only after the full OSR-bit period; the buffer is left alone.
                        state_q   <= IDLE;
                        acc_q     <= '0;
                        div_q     <= '0;
                        bit_q     <= '0;
                        busy_q    <= 1'b0;
                        pdm_clk_q <= 1'b0;
                        pdm_out_q <= 1'b0;
                     end else if (full_q) begin
                        // acc deliberately carries across sample loads.
                        cur_q <= buf_q;
                     end else begin
                        underrun_q <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_ready  = s_ready_q;
   assign pdm_clk  = pdm_clk_q;
   assign pdm_out  = pdm_out_q;
   assign busy     = busy_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_pdm_transmisor.sv
// tb/tb_pdm_transmisor.sv - self-checking bench for pdm_transmisor
module tb_pdm_transmisor;

   localparam int W   = 8;
   localparam int DIV = 4;
   localparam int OSR = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [W-1:0] s_data;
   logic         s_valid;
   logic         s_ready;
   logic         pdm_clk;
   logic         pdm_out;
   logic         busy;
   logic         underrun;

   pdm_transmisor #(.W(W), .DIV(DIV), .OSR(OSR)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .pdm_clk  (pdm_clk),
      .pdm_out  (pdm_out),
      .busy     (busy),
      .underrun (underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      int           ones;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted samples queue, bit-level sigma-delta reference
   logic [W-1:0] q[$];
   logic         hs_flag = 1'b0;
   logic [W-1:0] hs_data;
   logic [W-1:0] m_acc, m_cur;
   logic [W:0]   m_sum;
   int           m_bit;
   int           cyc = 0;
   int           tick_cnt, ones_cnt, under_cnt, bnd_cnt;
   int           last_rise, sample_start, entry_cyc, fall_cyc, under_cyc;
   logic         prev_busy, prev_pclk, exp_under;

   always @(posedge clk) begin
      if (reset && s_valid && s_ready) begin
         hs_flag = 1'b1;
         hs_data = s_data;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         q.delete();
         hs_flag   = 1'b0;
         prev_busy = 1'b0;
         prev_pclk = 1'b0;
         m_acc     = '0;
         m_cur     = '0;
         m_bit     = 0;
         tick_cnt  = 0;
         ones_cnt  = 0;
         under_cnt = 0;
         bnd_cnt   = 0;
      end else begin
         exp_under = 1'b0;
         if (busy && !prev_busy) begin
            check("entry_has_sample", int'(q.size() > 0), 1);
            if (q.size() > 0) m_cur = q.pop_front();
            m_acc        = '0;
            m_bit        = 0;
            sample_start = cyc;
            last_rise    = cyc;
            entry_cyc    = cyc;
         end else if (!busy && prev_busy) begin
            m_acc    = '0;
            m_bit    = 0;
            fall_cyc = cyc;
         end else if (busy && pdm_clk && !prev_pclk) begin
            m_sum = {1'b0, m_acc} + {1'b0, m_cur};
            check("pdm_bit", int'(pdm_out), int'(m_sum[W]));
            m_acc = m_sum[W-1:0];
            check("pdm_clk_period", cyc - last_rise, DIV);
            last_rise = cyc;
            tick_cnt++;
            ones_cnt += int'(pdm_out);
            m_bit++;
            if (m_bit == OSR) begin
               m_bit        = 0;
               bnd_cnt++;
               sample_start = cyc;
               if (q.size() > 0) m_cur = q.pop_front();
               else exp_under = 1'b1;
            end
         end else if (busy && !pdm_clk && prev_pclk) begin
            check("pdm_clk_high_time", cyc - last_rise, DIV / 2);
         end
         if (!busy) check("idle_outputs", int'({pdm_clk, pdm_out}), 0);
         check("underrun", int'(underrun), int'(exp_under));
         if (underrun) begin
            under_cnt++;
            if (under_cnt == 1) under_cyc = cyc;
         end
         if (hs_flag) begin
            q.push_back(hs_data);
            hs_flag = 1'b0;
         end
         prev_busy = busy;
         prev_pclk = pdm_clk;
      end
   end

   task automatic do_reset();
      en      = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      reset   = 1'b0;
      repeat (10) @(negedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ticks(input int n);
      for (int k = 0; k < 400 && tick_cnt < n; k++) step();
      check("wait_ticks_in_time", int'(tick_cnt >= n), 1);
   endtask

   task automatic send(input logic [W-1:0] d);
      s_data  = d;
      s_valid = 1'b1;
      for (int k = 0; k < 100 && !s_ready; k++) step();
      check("send_ready_in_time", int'(s_ready), 1);
      step();
      s_valid = 1'b0;
   endtask

   initial begin
      vec_t vecs[6];
      vecs[0] = '{8'h00, 0};
      vecs[1] = '{8'h80, 4};
      vecs[2] = '{8'h40, 2};
      vecs[3] = '{8'hFF, 7};
      vecs[4] = '{8'h20, 1};
      vecs[5] = '{8'hC0, 6};

      // Reset values after a 10-cycle reset
      do_reset();
      #1;
      check("rst_pdm_clk", int'(pdm_clk), 0);
      check("rst_pdm_out", int'(pdm_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_underrun", int'(underrun), 0);
      check("rst_s_ready", int'(s_ready), 1);

      // Constant-input density over the first sample period
      for (int i = 0; i < 6; i++) begin
         do_reset();
         s_data  = vecs[i].data;
         s_valid = 1'b1;
         en      = 1'b1;
         wait_ticks(8);
         check("ones_per_sample", ones_cnt, vecs[i].ones);
         check("no_underrun_streaming", under_cnt, 0);
      end

      // 0x00 then 0xFF: accumulator carries 0 into the 0xFF sample
      do_reset();
      en = 1'b1;
      send(8'h00);
      s_data  = 8'hFF;
      s_valid = 1'b1;
      wait_ticks(8);
      check("zeros_first_sample", ones_cnt, 0);
      wait_ticks(16);
      check("ones_ff_sample", ones_cnt, 7);
      check("no_underrun_00_ff", under_cnt, 0);

      // Single 0x40 then starve: underrun at the first boundary, density held
      do_reset();
      en = 1'b1;
      send(8'h40);
      wait_ticks(8);
      check("underrun_count_1", under_cnt, 1);
      check("underrun_latency", under_cyc - entry_cyc, 32);
      check("busy_after_underrun", int'(busy), 1);
      wait_ticks(16);
      check("ones_starved_16", ones_cnt, 4);
      check("underrun_count_2", under_cnt, 2);
      check("busy_still", int'(busy), 1);

      // Drop en at bit 3: period completes, buffer kept, then resumes from it
      do_reset();
      s_data  = 8'h80;
      s_valid = 1'b1;
      en      = 1'b1;
      for (int k = 0; k < 400 && !(bnd_cnt == 1 && m_bit == 3); k++) step();
      check("reached_bit3", int'(bnd_cnt == 1 && m_bit == 3), 1);
      check("buffer_full_before_drop", int'(s_ready), 0);
      en      = 1'b0;
      s_valid = 1'b0;
      for (int k = 0; k < 100 && busy; k++) step();
      check("idle_after_drop", int'(busy), 0);
      check("drop_full_period", fall_cyc - sample_start, DIV * OSR);
      check("drop_pdm_clk_low", int'(pdm_clk), 0);
      check("drop_buffer_kept", int'(s_ready), 0);
      repeat (3) step();
      check("drop_stays_idle", int'(busy), 0);
      en = 1'b1;
      for (int k = 0; k < 20 && !busy; k++) step();
      check("resume_busy", int'(busy), 1);
      step();
      check("resume_buffer_drained", int'(s_ready), 1);
      wait_ticks(tick_cnt + 4);

      // Asynchronous reset mid-sample with the buffer full
      do_reset();
      s_data  = 8'h80;
      s_valid = 1'b1;
      en      = 1'b1;
      wait_ticks(2);
      check("pre_reset_buffer_full", int'(s_ready), 0);
      check("pre_reset_pdm_out", int'(pdm_out), 1);
      s_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_pdm_clk", int'(pdm_clk), 0);
      check("async_pdm_out", int'(pdm_out), 0);
      check("async_busy", int'(busy), 0);
      check("async_underrun", int'(underrun), 0);
      check("async_s_ready", int'(s_ready), 1);
      repeat (5) @(negedge clk);
      #1 reset = 1'b1;
      repeat (3) step();
      check("post_reset_idle", int'(busy), 0);
      check("post_reset_s_ready", int'(s_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pdm_transmisor.md
PDM_TRANSMISOR -- requirements
Module: pdm_transmisor

Interface
REQ-001 Parameter W, default 8: PCM sample width in bits, unsigned.
REQ-002 Parameter DIV, default 4: clk cycles per PDM bit; even, >= 2.
REQ-003 Parameter OSR, default 8: PDM bits per PCM sample; >= 2.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run enable.
REQ-007 s_data  input  W  PCM sample, unsigned.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  buffer can accept a sample.
REQ-010 pdm_clk  output  1  bit clock to the DAC/filter, period DIV clk cycles.
REQ-011 pdm_out  output  1  PDM bitstream.
REQ-012 busy  output  1  high in RUN.
REQ-013 underrun  output  1  one-cycle pulse on a missed sample boundary.

Function
REQ-014 Handshake: sample transfers on the clk edge where s_valid=1 and s_ready=1, into a 1-entry buffer.
REQ-015 s_ready SHALL be registered, equal to NOT buffer_full; it never depends combinationally on s_valid.
REQ-016 States SHALL be IDLE and RUN only.
REQ-017 IDLE: divider count, bit count and accumulator held at 0; pdm_clk=0, pdm_out=0, busy=0.
REQ-018 IDLE->RUN when en=1 and buffer_full=1: buffer moves to current-sample register cur, buffer empties, busy=1 next cycle.
REQ-019 RUN: divider counts 0..DIV-1 and wraps; bit_tick is the cycle where the count equals DIV-1.
REQ-020 pdm_clk SHALL be registered, high while divider count is in 0..DIV/2-1, else low: 50% duty.
REQ-021 On each bit_tick: {carry, acc} = acc + cur, computed W+1 bits wide; acc takes the low W bits; pdm_out takes carry (first-order sigma-delta).
REQ-022 pdm_out and the pdm_clk rising edge SHALL update on the same clk edge; consumers sample on the pdm_clk falling edge.
REQ-023 Bit counter counts 0..OSR-1 on bit_tick and wraps; the sample boundary is the bit_tick with bit count = OSR-1.
REQ-024 At a sample boundary with buffer_full=1: cur loads from the buffer and the buffer empties.
REQ-025 At a sample boundary with buffer_full=0: cur is held and underrun=1 for exactly that following cycle.
REQ-026 At a sample boundary with en=0: go to IDLE, clear acc; the buffer keeps its contents.
REQ-027 Deasserting en mid-sample SHALL NOT truncate the current OSR-bit period.
REQ-028 acc SHALL NOT be cleared on sample loads, only on reset or IDLE entry.
REQ-029 Long-run pdm_out ones density SHALL equal cur/2^W; cur=0 gives all zeros.
REQ-030 Accept and drain SHALL never coincide, since accept requires an empty buffer and drain a full one.

Reset
REQ-031 While reset=0, asynchronously: state=IDLE; acc, cur, counters and buffer cleared; pdm_clk=0, pdm_out=0, busy=0, underrun=0, s_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard the buffered sample and the in-progress sample.
REQ-033 After reset release, the first transition SHALL follow REQ-018.

Verification (W=8, DIV=4, OSR=8)
REQ-034 Hold reset=0 for 10 clk cycles, release -> pdm_clk=0, pdm_out=0, busy=0, underrun=0, s_ready=1.
REQ-035 Feed s_data=0x80 continuously with en=1 -> pdm_out per bit is 0,1,0,1,... with 4 ones per 8 bits, and pdm_clk period is 4 clk cycles.
REQ-036 Feed 0x00 then 0xFF -> 8 zeros for the first sample; then acc carries 0 -> first 8 bits of 0xFF contain 7 ones, no underrun.
REQ-037 Load a single sample 0x40, then drop s_valid -> underrun pulse 32 clk cycles after RUN entry, pdm_out density stays 1/4, busy stays 1.
REQ-038 Drop en at bit 3 of a sample -> remaining bits complete, IDLE at the boundary, pdm_clk=0, buffer kept, s_ready unchanged.
REQ-039 Assert reset mid-sample with buffer full -> all outputs per REQ-031 within the same cycle; after release, IDLE with s_ready=1.
